// File: rtl/water_led_pkg.sv
// Shared types and constants for the water-LED select-code sequencer.
// Optional ping-pong stepping is enabled by defining WATER_LED_BOUNCE_EN.
package water_led_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned CNT_W  = 24;

  localparam logic [CNT_W-1:0] CNT_MAX_DEFAULT = 24'd9_999_999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef logic [CODE_W-1:0] code_t;

  // Modulo-8 step; the carry/borrow is dropped by the return width.
  function automatic code_t code_step(input code_t code, input logic down);
    return down ? (code - code_t'(1)) : (code + code_t'(1));
  endfunction

  // True when a step in the given direction has reached the far end of the range.
  function automatic logic code_at_end(input code_t code, input logic down);
    return down ? (code == '0) : (code == '1);
  endfunction

endpackage

// File: rtl/water_led_dwell.sv
// Dwell counter: counts enabled clocks and flags the terminal count,
// wrapping to zero on the enabled edge that follows the terminal count.
module water_led_dwell
  import water_led_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign o_tc = (r_cnt == CNT_MAX);

  // Clear wins over enable so a HOLD->IDLE exit always lands on zero.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      w_cnt_nxt = o_tc ? '0 : (r_cnt + CNT_W'(1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/water_led_seq.sv
// Water-LED sequencer: steps a 3-bit decoder select code once per dwell period.
// Define WATER_LED_BOUNCE_EN for ping-pong stepping instead of modulo-8 wrap.
module water_led_seq
  import water_led_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  output logic [CODE_W-1:0] code_out,
  output logic              step_vld,
  output logic              run
);

  state_e r_state;
  state_e w_state_nxt;

  code_t  r_code;
  code_t  w_code_nxt;
  logic   r_step_vld;

  logic   w_tc;
  logic   w_cnt_en;
  logic   w_clear;
  logic   w_step;
  logic   w_step_down;

  // stop dominates: it suppresses counting and stepping on the edge it is seen.
  assign w_cnt_en = (r_state == RUN) && !stop;
  assign w_step   = w_cnt_en && w_tc;
  assign w_clear  = (r_state == HOLD) && stop;

  water_led_dwell #(
    .CNT_MAX (CNT_MAX)
  ) u_dwell (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_en    (w_cnt_en),
    .i_clr   (w_clear),
    .o_tc    (w_tc)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run      = (r_state == RUN);
    code_out = r_code;
    step_vld = r_step_vld;
  end

`ifdef WATER_LED_BOUNCE_EN
  logic r_dir;
  logic w_load_dir;

  assign w_load_dir  = (r_state == IDLE) && (w_state_nxt == RUN);
  assign w_step_down = r_dir;

  // Direction is latched at launch, then reverses whenever a step hits an end.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dir <= 1'b0;
    end else if (w_load_dir) begin
      r_dir <= dir;
    end else if (w_step && code_at_end(w_code_nxt, r_dir)) begin
      r_dir <= ~r_dir;
    end
  end
`else
  assign w_step_down = dir;
`endif

  assign w_code_nxt = code_step(r_code, w_step_down);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_code     <= '0;
      r_step_vld <= 1'b0;
    end else begin
      r_step_vld <= w_step;
      if (w_clear) begin
        r_code <= '0;
      end else if (w_step) begin
        r_code <= w_code_nxt;
      end
    end
  end

endmodule

// File: tb/tb_water_led_seq.sv
// Self-checking bench for water_led_seq with CNT_MAX=3 (4-clock dwell).
// Expected values come from directed constants and a cycle-level behavioural model.
module tb_water_led_seq;

  localparam int CntMax = 3;
  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MHold  = 2;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       start;
  logic       stop;
  logic       dir;
  logic [2:0] code_out;
  logic       step_vld;
  logic       run;

  int n_checks;
  int n_fail;
  int cyc;

  // Behavioural reference: operating mode, clocks spent in the current dwell, code.
  int m_mode;
  int m_elapsed;
  int m_code;
  int m_step;
  int m_down;

  water_led_seq #(
    .CNT_MAX (24'(CntMax))
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .code_out  (code_out),
    .step_vld  (step_vld),
    .run       (run)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = MIdle;
    m_elapsed = 0;
    m_code    = 0;
    m_step    = 0;
    m_down    = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied, then
  // clock the DUT and compare all outputs shortly after the edge.
  task automatic tick();
    int down;
    m_step = 0;
    if (m_mode == MIdle) begin
      if (start && !stop) begin
        m_mode = MRun;
        m_down = int'(dir);
      end
    end else if (m_mode == MRun) begin
      if (stop) begin
        m_mode = MHold;
      end else if (m_elapsed == CntMax) begin
        m_elapsed = 0;
        m_step    = 1;
`ifdef WATER_LED_BOUNCE_EN
        down = m_down;
`else
        down = int'(dir);
`endif
        m_code = down ? (m_code + 7) % 8 : (m_code + 1) % 8;
`ifdef WATER_LED_BOUNCE_EN
        if (down == 0 && m_code == 7) m_down = 1;
        else if (down == 1 && m_code == 0) m_down = 0;
`endif
      end else begin
        m_elapsed++;
      end
    end else begin
      if (stop) begin
        m_mode    = MIdle;
        m_code    = 0;
        m_elapsed = 0;
      end else if (start) begin
        m_mode = MRun;
      end
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    chk("model_code", int'(code_out), m_code);
    chk("model_step_vld", int'(step_vld), m_step);
    chk("model_run", int'(run), (m_mode == MRun) ? 1 : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    start     = 1'b0;
    stop      = 1'b0;
    dir       = 1'b0;
    sys_rst_n = 1'b1;
    model_reset();

    // Reset state.
    #2 sys_rst_n = 1'b0;
    #1;
    chk("reset_code", int'(code_out), 0);
    chk("reset_step_vld", int'(step_vld), 0);
    chk("reset_run", int'(run), 0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // First dwell timing: run at cycle 1, steps at 5, 9, 13.
    cyc = 0;
    pulse_start();
    chk("start_run_cycle1", int'(run), 1);
    while (cyc < 13) begin
      tick();
      chk("seq_step_vld", int'(step_vld), (cyc == 5 || cyc == 9 || cyc == 13) ? 1 : 0);
      if (cyc == 5 || cyc == 9 || cyc == 13) chk("seq_code", int'(code_out), cyc / 4);
    end

    // Through 7 and one more step.
    while (cyc < 33) tick();
`ifdef WATER_LED_BOUNCE_EN
    chk("after7_code", int'(code_out), 6);
`else
    chk("after7_code", int'(code_out), 0);
`endif
    chk("after7_step_vld", int'(step_vld), 1);

    // Back to IDLE via HOLD.
    pulse_stop();
    pulse_stop();
    chk("clear_code", int'(code_out), 0);
    chk("clear_run", int'(run), 0);

    // Pause at cnt=1 with code=2, then resume with 3 clocks left.
    pulse_start();
    repeat (9) tick();
    chk("pre_hold_code", int'(code_out), 2);
    pulse_stop();
    repeat (20) begin
      tick();
      chk("hold_code", int'(code_out), 2);
      chk("hold_step_vld", int'(step_vld), 0);
    end
    pulse_start();
    chk("resume_run", int'(run), 1);
    tick();
    tick();
    chk("resume_no_step", int'(step_vld), 0);
    tick();
    chk("resume_code", int'(code_out), 3);
    chk("resume_step_vld", int'(step_vld), 1);

    // Clear from HOLD with a partial dwell, then a full 4-clock dwell.
    tick();
    pulse_stop();
    pulse_stop();
    chk("clear2_code", int'(code_out), 0);
    pulse_start();
    repeat (3) tick();
    chk("full_dwell_no_step", int'(code_out), 0);
    tick();
    chk("full_dwell_code", int'(code_out), 1);

    // Simultaneous start and stop: RUN->HOLD, IDLE stays IDLE.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("both_run_to_hold", int'(run), 0);
    chk("both_run_code", int'(code_out), 1);
    pulse_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) tick();
    chk("both_idle_run", int'(run), 0);

    // Counting down from 0 wraps to 7.
    dir = 1'b1;
    pulse_start();
    repeat (4) tick();
    chk("down_wrap_code", int'(code_out), 7);

    // stop at the terminal count: no step, then step on the first RUN edge.
    repeat (3) tick();
    pulse_stop();
    chk("tc_stop_code", int'(code_out), 7);
    chk("tc_stop_step", int'(step_vld), 0);
    repeat (2) tick();
    pulse_start();
    tick();
    chk("tc_resume_step", int'(step_vld), 1);
    chk("tc_resume_code", int'(code_out), 6);

    // Asynchronous reset mid-dwell at code 5.
    pulse_stop();
    pulse_stop();
    dir = 1'b0;
    pulse_start();
    repeat (22) tick();
    chk("pre_reset_code", int'(code_out), 5);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_code", int'(code_out), 0);
    chk("async_step_vld", int'(step_vld), 0);
    chk("async_run", int'(run), 0);
    model_reset();
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (5) tick();
    chk("post_reset_idle", int'(run), 0);

    // Randomized control traffic against the model.
    repeat (400) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 14) == 0);
      dir   = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
